// File: rtl/ddr_judge.sv
// N-lane hit judge: grades arrow rows against button presses within a timing window and
// keeps score, combo, multiplier, lives and the IDLE/PLAY/PAUSE/OVER game state.
module ddr_judge #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned WIN_BITS    = 4,
  parameter int unsigned PERFECT_WIN = 2,
  parameter int unsigned GOOD_WIN    = 9,
  parameter int unsigned SCORE_BITS  = 14,
  parameter int unsigned COMBO_BITS  = 14,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned MULT_STEP   = 10,
  parameter int unsigned MULT_MAX    = 8,
  parameter int unsigned PERFECT_PTS = 2,
  parameter int unsigned GOOD_PTS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  beat,
  input  logic [NUM_LANES-1:0]  target,
  input  logic [NUM_LANES-1:0]  btn,
  output logic [1:0]            state,
  output logic [SCORE_BITS-1:0] score,
  output logic [COMBO_BITS-1:0] combo,
  output logic [3:0]            multiplier,
  output logic [3:0]            lives,
  output logic                  hit_perfect,
  output logic                  hit_good,
  output logic                  miss
);

  typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StPause = 2'd2, StOver = 2'd3} state_e;

  localparam int unsigned StepW = $clog2(MULT_STEP + 1);

  state_e                state_q, state_d;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic [COMBO_BITS-1:0] combo_q, combo_d;
  logic [3:0]            mult_q, mult_d;
  logic [3:0]            lives_q, lives_d;
  logic [StepW-1:0]      step_q, step_d;
  logic                  pend_q, pend_d;
  logic [NUM_LANES-1:0]  tgt_q, tgt_d;
  logic [NUM_LANES-1:0]  acc_q, acc_d;
  logic [WIN_BITS-1:0]   wcnt_q, wcnt_d;
  logic [NUM_LANES-1:0]  btn_q;
  logic                  perfect_q, perfect_d;
  logic                  good_q, good_d;
  logic                  miss_q, miss_d;

  logic [NUM_LANES-1:0]  press;
  logic                  do_hit, do_miss, is_perf;
  int unsigned           pts;
  logic [SCORE_BITS:0]   score_sum;

  assign press = btn & ~btn_q;

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    combo_d   = combo_q;
    mult_d    = mult_q;
    lives_d   = lives_q;
    step_d    = step_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    acc_d     = acc_q;
    wcnt_d    = wcnt_q;
    perfect_d = 1'b0;
    good_d    = 1'b0;
    miss_d    = 1'b0;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    is_perf   = 1'b0;
    pts       = 0;
    score_sum = '0;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StPlay;
          score_d = '0;
          combo_d = '0;
          mult_d  = 4'd1;
          lives_d = 4'(LIVES_INIT);
          step_d  = '0;
          pend_d  = 1'b0;
          acc_d   = '0;
          wcnt_d  = '0;
        end
      end
      StPause: begin
        if (!pause) state_d = StPlay;
      end
      StPlay: begin
        if (pend_q) begin
          if (|(press & ~tgt_q)) begin
            do_miss = 1'b1;
            pend_d  = 1'b0;
          end else if ((acc_q | (press & tgt_q)) == tgt_q) begin
            do_hit  = 1'b1;
            is_perf = (wcnt_q <= WIN_BITS'(PERFECT_WIN));
            pend_d  = 1'b0;
          end else if (wcnt_q == WIN_BITS'(GOOD_WIN)) begin
            do_miss = 1'b1;
            pend_d  = 1'b0;
          end else begin
            acc_d  = acc_q | (press & tgt_q);
            wcnt_d = wcnt_q + WIN_BITS'(1);
          end
          // A new row displaces an old one that did not grade itself this cycle
          if (beat && (target != '0) && !do_hit && !do_miss) do_miss = 1'b1;
        end
        if (beat && (target != '0)) begin
          pend_d = 1'b1;
          tgt_d  = target;
          acc_d  = '0;
          wcnt_d = '0;
        end
        if (pause) state_d = StPause;
      end
      default: ;
    endcase

    if (do_hit) begin
      perfect_d = is_perf;
      good_d    = !is_perf;
      combo_d   = (combo_q == '1) ? combo_q : combo_q + COMBO_BITS'(1);
      if (step_q == StepW'(MULT_STEP - 1)) begin
        step_d = '0;
        mult_d = (mult_q >= 4'(MULT_MAX)) ? mult_q : mult_q + 4'd1;
      end else begin
        step_d = step_q + StepW'(1);
      end
      pts       = is_perf ? PERFECT_PTS : GOOD_PTS;
      score_sum = {1'b0, score_q} + (SCORE_BITS + 1)'(pts * mult_q);
      score_d   = score_sum[SCORE_BITS] ? '1 : score_sum[SCORE_BITS-1:0];
    end

    if (do_miss) begin
      miss_d  = 1'b1;
      combo_d = '0;
      step_d  = '0;
      mult_d  = 4'd1;
      lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
      if (lives_d == 4'd0) state_d = StOver;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      score_q   <= '0;
      combo_q   <= '0;
      mult_q    <= 4'd1;
      lives_q   <= 4'd0;
      step_q    <= '0;
      pend_q    <= 1'b0;
      tgt_q     <= '0;
      acc_q     <= '0;
      wcnt_q    <= '0;
      btn_q     <= '0;
      perfect_q <= 1'b0;
      good_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      mult_q    <= mult_d;
      lives_q   <= lives_d;
      step_q    <= step_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
      acc_q     <= acc_d;
      wcnt_q    <= wcnt_d;
      btn_q     <= btn;
      perfect_q <= perfect_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
    end
  end

  assign state       = state_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign multiplier  = mult_q;
  assign lives       = lives_q;
  assign hit_perfect = perfect_q;
  assign hit_good    = good_q;
  assign miss        = miss_q;

endmodule
